queue_fifo: RTL and testbench
=============================

QUEUE_FIFO -- requirements
Module: queue_fifo

Interface
REQ-001 Parameter DATA_WIDTH, default 8, SHALL set the data word width.
REQ-002 Parameter DEPTH, default 8, power of two, SHALL set the number of storage entries.
REQ-003 Parameter ADDR_WIDTH, default 3, SHALL equal log2(DEPTH) and size the pointers.
REQ-004 clk  input  1  SHALL be the single clock; all state changes on its rising edge.
REQ-005 reset  input  1  SHALL be asynchronous, active-low; 0 clears state immediately.
REQ-006 push  input  1  SHALL request a write of push_data this cycle.
REQ-007 pop  input  1  SHALL request a read of the oldest entry this cycle.
REQ-008 push_data  input  DATA_WIDTH  SHALL be the word written on an accepted push.
REQ-009 pop_data  output  DATA_WIDTH  SHALL be the registered word from the last accepted pop.
REQ-010 empty  output  1  SHALL be high when count == 0.
REQ-011 full  output  1  SHALL be high when count == DEPTH.
REQ-012 count  output  ADDR_WIDTH+1  SHALL give the number of stored entries, 0..DEPTH.
REQ-013 overflow  output  1  SHALL pulse one cycle when a push is rejected.
REQ-014 underflow  output  1  SHALL pulse one cycle when a pop is rejected.

Function
REQ-015 Storage SHALL be first-in first-out: words leave in the order they were accepted.
REQ-016 Write pointer and read pointer SHALL be ADDR_WIDTH bits and wrap from DEPTH-1 to 0.
REQ-017 Accepted push: mem[wr_ptr] <= push_data, wr_ptr increments, count increments.
REQ-018 Accepted pop: pop_data <= mem[rd_ptr], rd_ptr increments, count decrements; pop_data valid the clock edge after pop is sampled (latency 1).
REQ-019 pop_data SHALL hold its previous value in every cycle without an accepted pop.
REQ-020 Push with full=1 and pop=0 SHALL be rejected: no state change, overflow=1 for the next cycle.
REQ-021 Pop with empty=1 SHALL be rejected: pop_data, rd_ptr and count unchanged, underflow=1 for the next cycle.
REQ-022 Push and pop together, 0 < count < DEPTH: both accepted, count unchanged, both pointers advance.
REQ-023 Push and pop together with full=1: both accepted (pop reads the old head, push fills the freed slot), count stays DEPTH, no overflow.
REQ-024 Push and pop together with empty=1: push accepted, pop rejected, count becomes 1, underflow pulses, pop_data unchanged.
REQ-025 empty, full and count SHALL be registered and consistent with each other every cycle.
REQ-026 overflow and underflow SHALL be registered, one cycle wide per rejected request, and never sticky.

Reset
REQ-027 reset=0 SHALL clear, without waiting for clk, wr_ptr, rd_ptr, count, pop_data (0), full (0), overflow (0) and underflow (0), and SHALL set empty to 1.
REQ-028 Memory contents SHALL be left uncleared and never observable after reset until rewritten.
REQ-029 Reset during a push or pop SHALL discard the operation; the first edge after release with reset=1 SHALL be the first active cycle.

Verification
REQ-030 Push 0x35, 0xA6, 0x5A on three edges, then pop three times -> pop_data 0x35, 0xA6, 0x5A in that order; count 3 then 0; empty=1 at the end.
REQ-031 Push 0x01..0x08 -> full=1, count=8; ninth push 0xFF -> overflow pulses one cycle, count stays 8; popping 8 times returns 0x01..0x08 and never 0xFF.
REQ-032 From reset, pop with empty=1 -> underflow pulses one cycle, pop_data stays 0x00, count stays 0.
REQ-033 Wrap-around: push 6, pop 6, then push 0x10..0x17 -> full=1; pop 8 -> 0x10..0x17 in order across the pointer wrap.
REQ-034 Simultaneous push and pop in three states: count=3 -> count stays 3; full -> count stays 8 and the old head is returned; empty -> count 1, underflow pulses.
REQ-035 Assert reset mid-burst, between edges, with count=5 -> all outputs reach reset values before the next edge; after release, push 0xC3 then pop -> 0xC3.

Source files
------------

// File: rtl/queue_fifo.sv
// ---------------------------------------------------------------------------
// queue_fifo
//
// Synchronous first-in first-out queue with registered read data and
// registered status flags.
//
// Ports:
//   clk        - single clock, all state changes on its rising edge
//   reset      - asynchronous, active-low; clears pointers, count and flags
//   push       - request to write push_data this cycle
//   pop        - request to read the oldest entry this cycle
//   push_data  - word written on an accepted push
//   pop_data   - registered word from the most recent accepted pop
//   empty      - high when no entries are stored
//   full       - high when DEPTH entries are stored
//   count      - number of stored entries, 0..DEPTH
//   overflow   - one-cycle pulse after a rejected push
//   underflow  - one-cycle pulse after a rejected pop
// ---------------------------------------------------------------------------
module queue_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 8,
    parameter int ADDR_WIDTH = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  push,
    input  logic                  pop,
    input  logic [DATA_WIDTH-1:0] push_data,
    output logic [DATA_WIDTH-1:0] pop_data,
    output logic                  empty,
    output logic                  full,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  overflow,
    output logic                  underflow
);

    localparam logic [ADDR_WIDTH:0] FULL_COUNT = (ADDR_WIDTH+1)'(DEPTH);

    // Storage is deliberately not reset; it is only ever read at rd_ptr,
    // which never points at a slot that was not written since reset.
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_WIDTH:0]   count_q, count_d;
    logic [DATA_WIDTH-1:0] pop_data_q, pop_data_d;
    logic                  empty_q, empty_d;
    logic                  full_q, full_d;
    logic                  overflow_q, overflow_d;
    logic                  underflow_q, underflow_d;

    logic push_acc;
    logic pop_acc;

    // A pop only needs something to read. A push into a full queue is still
    // accepted when a pop in the same cycle frees the head slot.
    always_comb begin
        pop_acc  = pop && !empty_q;
        push_acc = push && (!full_q || pop_acc);
    end

    // Next-state computation for pointers, occupancy, flags and read data.
    // Flags are derived from the next count so they register together with
    // it and always agree with the count output.
    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        pop_data_d  = pop_data_q;
        overflow_d  = push && !push_acc;
        underflow_d = pop && !pop_acc;

        if (push_acc) begin
            wr_ptr_d = wr_ptr_q + ADDR_WIDTH'(1);
        end

        if (pop_acc) begin
            rd_ptr_d   = rd_ptr_q + ADDR_WIDTH'(1);
            pop_data_d = mem[rd_ptr_q];
        end

        case ({push_acc, pop_acc})
            2'b10:   count_d = count_q + (ADDR_WIDTH+1)'(1);
            2'b01:   count_d = count_q - (ADDR_WIDTH+1)'(1);
            default: count_d = count_q;
        endcase

        empty_d = (count_d == '0);
        full_d  = (count_d == FULL_COUNT);
    end

    // Control and status registers, cleared asynchronously by reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            pop_data_q  <= '0;
            empty_q     <= 1'b1;
            full_q      <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            pop_data_q  <= pop_data_d;
            empty_q     <= empty_d;
            full_q      <= full_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Storage write; gated by reset so an edge seen while reset is held
    // low cannot sneak a write in.
    always_ff @(posedge clk) begin
        if (reset && push_acc) begin
            mem[wr_ptr_q] <= push_data;
        end
    end

    assign pop_data  = pop_data_q;
    assign empty     = empty_q;
    assign full      = full_q;
    assign count     = count_q;
    assign overflow  = overflow_q;
    assign underflow = underflow_q;

endmodule

// File: tb/tb_queue_fifo.sv
// ---------------------------------------------------------------------------
// tb_queue_fifo
//
// Self-checking bench for queue_fifo. A queue holds the words the FIFO
// should contain; it is pushed when an accepted push is driven and popped
// when the DUT is expected to present the word on pop_data.
// ---------------------------------------------------------------------------
module tb_queue_fifo;

    logic       clk;
    logic       reset;
    logic       push;
    logic       pop;
    logic [7:0] push_data;
    logic [7:0] pop_data;
    logic       empty;
    logic       full;
    logic [3:0] count;
    logic       overflow;
    logic       underflow;

    int totalChecks;
    int badChecks;

    logic [7:0] scoreboard[$];
    logic [7:0] lastPopData;

    queue_fifo #(
        .DATA_WIDTH(8),
        .DEPTH     (8),
        .ADDR_WIDTH(3)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .push     (push),
        .pop      (pop),
        .push_data(push_data),
        .pop_data (pop_data),
        .empty    (empty),
        .full     (full),
        .count    (count),
        .overflow (overflow),
        .underflow(underflow)
    );

    // Free-running clock, 10 time units per period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        totalChecks++;
        if (got !== exp) begin
            badChecks++;
            $display("[TB] FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Drives one cycle of push/pop, predicts the result from the scoreboard
    // and compares every output just after the edge.
    task automatic applyStimulus(input logic doPush, input logic doPop, input logic [7:0] data);
        bit popOk;
        bit pushOk;
        bit expOvf;
        bit expUnf;
        @(negedge clk);
        push      = doPush;
        pop       = doPop;
        push_data = data;
        popOk  = doPop && (scoreboard.size() > 0);
        pushOk = doPush && ((scoreboard.size() < 8) || popOk);
        expOvf = doPush && !pushOk;
        expUnf = doPop && !popOk;
        if (popOk) lastPopData = scoreboard.pop_front();
        if (pushOk) scoreboard.push_back(data);
        @(posedge clk);
        #1;
        push = 1'b0;
        pop  = 1'b0;
        checkOutput("pop_data", 32'(pop_data), 32'(lastPopData));
        checkOutput("count", 32'(count), 32'(scoreboard.size()));
        checkOutput("empty", 32'(empty), 32'(scoreboard.size() == 0));
        checkOutput("full", 32'(full), 32'(scoreboard.size() == 8));
        checkOutput("overflow", 32'(overflow), 32'(expOvf));
        checkOutput("underflow", 32'(underflow), 32'(expUnf));
    endtask

    // Full reset pulse between edges, then checks the reset values.
    task automatic doReset();
        @(negedge clk);
        reset = 1'b0;
        push  = 1'b0;
        pop   = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        scoreboard.delete();
        lastPopData = 8'h00;
        #1;
        checkOutput("rst_count", 32'(count), 32'd0);
        checkOutput("rst_empty", 32'(empty), 32'd1);
        checkOutput("rst_full", 32'(full), 32'd0);
        checkOutput("rst_pop_data", 32'(pop_data), 32'd0);
        checkOutput("rst_overflow", 32'(overflow), 32'd0);
        checkOutput("rst_underflow", 32'(underflow), 32'd0);
    endtask

    initial begin
        totalChecks = 0;
        badChecks   = 0;
        lastPopData = 8'h00;
        reset       = 1'b0;
        push        = 1'b0;
        pop         = 1'b0;
        push_data   = 8'h00;

        doReset();

        // Three pushes then three pops, order preserved.
        applyStimulus(1, 0, 8'h35);
        applyStimulus(1, 0, 8'hA6);
        applyStimulus(1, 0, 8'h5A);
        checkOutput("seq_count3", 32'(count), 32'd3);
        applyStimulus(0, 1, 8'h00);
        checkOutput("seq_pop0", 32'(pop_data), 32'h35);
        applyStimulus(0, 1, 8'h00);
        checkOutput("seq_pop1", 32'(pop_data), 32'hA6);
        applyStimulus(0, 1, 8'h00);
        checkOutput("seq_pop2", 32'(pop_data), 32'h5A);
        checkOutput("seq_empty", 32'(empty), 32'd1);

        // Fill, reject a ninth push, then drain.
        for (int i = 1; i <= 8; i++) applyStimulus(1, 0, 8'(i));
        checkOutput("fill_full", 32'(full), 32'd1);
        applyStimulus(1, 0, 8'hFF);
        checkOutput("ovf_pulse", 32'(overflow), 32'd1);
        checkOutput("ovf_count", 32'(count), 32'd8);
        applyStimulus(0, 0, 8'h00);
        checkOutput("ovf_clear", 32'(overflow), 32'd0);
        for (int i = 1; i <= 8; i++) begin
            applyStimulus(0, 1, 8'h00);
            checkOutput("drain_val", 32'(pop_data), 32'(i));
        end

        // Underflow straight from reset.
        doReset();
        applyStimulus(0, 1, 8'h00);
        checkOutput("unf_pulse", 32'(underflow), 32'd1);
        checkOutput("unf_pop_data", 32'(pop_data), 32'd0);
        applyStimulus(0, 0, 8'h00);
        checkOutput("unf_clear", 32'(underflow), 32'd0);

        // Wrap-around of both pointers.
        for (int i = 0; i < 6; i++) applyStimulus(1, 0, 8'(8'h60 + i));
        for (int i = 0; i < 6; i++) applyStimulus(0, 1, 8'h00);
        for (int i = 0; i < 8; i++) applyStimulus(1, 0, 8'(8'h10 + i));
        checkOutput("wrap_full", 32'(full), 32'd1);
        for (int i = 0; i < 8; i++) begin
            applyStimulus(0, 1, 8'h00);
            checkOutput("wrap_val", 32'(pop_data), 32'(8'h10 + i));
        end

        // Simultaneous push and pop: partially filled, full, empty.
        for (int i = 0; i < 3; i++) applyStimulus(1, 0, 8'(8'h20 + i));
        applyStimulus(1, 1, 8'h23);
        checkOutput("pp_mid_count", 32'(count), 32'd3);
        checkOutput("pp_mid_data", 32'(pop_data), 32'h20);
        for (int i = 0; i < 5; i++) applyStimulus(1, 0, 8'(8'h24 + i));
        checkOutput("pp_full_pre", 32'(full), 32'd1);
        applyStimulus(1, 1, 8'h29);
        checkOutput("pp_full_count", 32'(count), 32'd8);
        checkOutput("pp_full_data", 32'(pop_data), 32'h21);
        checkOutput("pp_full_ovf", 32'(overflow), 32'd0);
        for (int i = 0; i < 8; i++) applyStimulus(0, 1, 8'h00);
        applyStimulus(1, 1, 8'h3C);
        checkOutput("pp_empty_count", 32'(count), 32'd1);
        checkOutput("pp_empty_unf", 32'(underflow), 32'd1);
        checkOutput("pp_empty_data", 32'(pop_data), 32'h29);
        applyStimulus(0, 1, 8'h00);
        checkOutput("pp_empty_val", 32'(pop_data), 32'h3C);

        // Random traffic against the scoreboard.
        for (int i = 0; i < 300; i++) begin
            applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'($urandom));
        end

        // Reset asserted between edges in the middle of a burst.
        doReset();
        for (int i = 0; i < 5; i++) applyStimulus(1, 0, 8'(8'h40 + i));
        checkOutput("mid_count5", 32'(count), 32'd5);
        push      = 1'b1;
        push_data = 8'h77;
        #2;
        reset = 1'b0;
        #1;
        checkOutput("mid_rst_count", 32'(count), 32'd0);
        checkOutput("mid_rst_empty", 32'(empty), 32'd1);
        checkOutput("mid_rst_full", 32'(full), 32'd0);
        checkOutput("mid_rst_pop_data", 32'(pop_data), 32'd0);
        checkOutput("mid_rst_overflow", 32'(overflow), 32'd0);
        checkOutput("mid_rst_underflow", 32'(underflow), 32'd0);
        @(posedge clk);
        @(negedge clk);
        push  = 1'b0;
        reset = 1'b1;
        scoreboard.delete();
        lastPopData = 8'h00;
        applyStimulus(0, 0, 8'h00);
        checkOutput("post_rst_count", 32'(count), 32'd0);
        applyStimulus(1, 0, 8'hC3);
        applyStimulus(0, 1, 8'h00);
        checkOutput("post_rst_val", 32'(pop_data), 32'hC3);

        $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
        $finish;
    end

endmodule
